// File: rtl/fios_serial_pkg.sv
// Shared types and width helpers for the serial FIOS Montgomery multiplier.
package fios_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        SUB,
        OUT
    } state_e;

    // Counter wide enough to hold 0..s (inner loop runs one past the last word)
    function automatic int cnt_w(input int s);
        return (s < 1) ? 1 : $clog2(s + 1);
    endfunction

    // Index into an s-entry word array
    function automatic int idx_w(input int s);
        return (s <= 1) ? 1 : $clog2(s);
    endfunction

    function automatic int carry_w(input int w);
        return w + 2;
    endfunction

    function automatic int x_w(input int w);
        return 2 * w + 2;
    endfunction

endpackage

// File: rtl/fios_mac_word.sv
// Single FIOS word step: x = t + a*b + m*p + carry, with m generated on the j=0 step.
module fios_mac_word
    import fios_serial_pkg::*;
#(
    parameter int W = 17
) (
    input  logic         j0_i,
    input  logic [W-1:0] t_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] p_i,
    input  logic [W-1:0] m_i,
    input  logic [W-1:0] p_prime_0_i,
    input  logic [W+1:0] carry_i,
    output logic [W-1:0] x_lo_o,
    output logic [W+1:0] carry_o,
    output logic [W-1:0] m_o
);
    localparam int XW = x_w(W);

    logic [W-1:0]  u_lo;
    logic [W-1:0]  m_new;
    logic [W-1:0]  m_sel;
    logic [W+1:0]  carry_eff;
    logic [XW-1:0] x;

    // The first word of a row starts a fresh carry chain, so any stale carry is dropped.
    always_comb begin
        u_lo      = t_i + a_i * b_i;
        m_new     = u_lo * p_prime_0_i;
        m_sel     = j0_i ? m_new : m_i;
        carry_eff = j0_i ? '0 : carry_i;
        x         = XW'(t_i) + XW'(a_i) * XW'(b_i) + XW'(m_sel) * XW'(p_i) + XW'(carry_eff);
    end

    assign x_lo_o  = x[W-1:0];
    assign carry_o = x[XW-1:W];
    assign m_o     = m_sel;

endmodule

// File: rtl/fios_mm_serial.sv
// Word-serial FIOS Montgomery multiplier: res = a*b*R^-1 mod p, R = 2^(W*S).
module fios_mm_serial
    import fios_serial_pkg::*;
#(
    parameter int W         = 17,
    parameter int S         = 8,
    parameter int FINAL_SUB = 1
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [W-1:0] p_prime_0_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] p_i,
    output logic         busy_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] res_o,
    output logic         out_last_o
);
    localparam int CW = cnt_w(S);
    localparam int IW = idx_w(S);
    localparam logic [CW-1:0] J_LAST      = CW'(S);
    localparam logic [CW-1:0] J_LOAD_LAST = CW'(S - 1);
    localparam logic [IW-1:0] K_LAST      = IW'(S - 1);

    state_e state_q, state_d;

    logic [CW-1:0] j_q;
    logic [IW-1:0] i_q;
    logic [IW-1:0] k_q;
    logic [W-1:0]  a_q [S];
    logic [W-1:0]  b_q [S];
    logic [W-1:0]  p_q [S];
    logic [W-1:0]  d_q [S];
    logic [W-1:0]  t_q [S+1];
    logic [W-1:0]  pp0_q;
    logic [W-1:0]  m_q;
    logic [W+1:0]  carry_q;
    logic          borrow_q;
    logic          use_d_q;

    logic [IW-1:0] j_idx;
    logic [CW-1:0] j_prev;
    logic          j_first;
    logic          j_last;
    logic [W-1:0]  mac_a;
    logic [W-1:0]  mac_p;
    logic [W-1:0]  mac_lo;
    logic [W+1:0]  mac_carry;
    logic [W-1:0]  mac_m;
    logic [W:0]    sub_diff;
    logic [W-1:0]  res_word;

    assign j_idx   = IW'(j_q);
    assign j_prev  = j_q - CW'(1);
    assign j_first = (j_q == '0);
    assign j_last  = (j_q == J_LAST);

    // The closing step of each row only folds the carry into t[S]; operands are zeroed.
    assign mac_a = j_last ? '0 : a_q[j_idx];
    assign mac_p = j_last ? '0 : p_q[j_idx];

    fios_mac_word #(.W(W)) u_mac (
        .j0_i        (j_first),
        .t_i         (t_q[j_q]),
        .a_i         (mac_a),
        .b_i         (b_q[i_q]),
        .p_i         (mac_p),
        .m_i         (m_q),
        .p_prime_0_i (pp0_q),
        .carry_i     (carry_q),
        .x_lo_o      (mac_lo),
        .carry_o     (mac_carry),
        .m_o         (mac_m)
    );

    assign sub_diff = {1'b0, t_q[CW'(k_q)]} - {1'b0, p_q[k_q]} - {{W{1'b0}}, borrow_q};
    assign res_word = use_d_q ? d_q[k_q] : t_q[CW'(k_q)];

    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = LOAD;
            LOAD: if (in_valid_i && j_q == J_LOAD_LAST) state_d = CALC;
            CALC: if (j_last && i_q == K_LAST) state_d = (FINAL_SUB != 0) ? SUB : OUT;
            SUB:  if (k_q == K_LAST) state_d = OUT;
            OUT:  if (out_ready_i && k_q == K_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            j_q      <= '0;
            i_q      <= '0;
            k_q      <= '0;
            borrow_q <= 1'b0;
            use_d_q  <= 1'b0;
            for (int n = 0; n <= S; n++) t_q[n] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        pp0_q <= p_prime_0_i;
                        j_q   <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid_i) begin
                        a_q[j_idx] <= a_i;
                        b_q[j_idx] <= b_i;
                        p_q[j_idx] <= p_i;
                        if (j_q == J_LOAD_LAST) begin
                            j_q <= '0;
                            i_q <= '0;
                            for (int n = 0; n <= S; n++) t_q[n] <= '0;
                        end else begin
                            j_q <= j_q + CW'(1);
                        end
                    end
                end
                CALC: begin
                    carry_q <= mac_carry;
                    // Word 0 of a row always reduces to zero; only m is kept from it.
                    if (j_first) m_q <= mac_m;
                    else         t_q[j_prev] <= mac_lo;
                    if (j_last) begin
                        t_q[S]   <= W'(mac_carry);
                        j_q      <= '0;
                        i_q      <= i_q + IW'(1);
                        k_q      <= '0;
                        borrow_q <= 1'b0;
                        use_d_q  <= 1'b0;
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                end
                SUB: begin
                    d_q[k_q] <= sub_diff[W-1:0];
                    borrow_q <= sub_diff[W];
                    if (k_q == K_LAST) begin
                        use_d_q <= (t_q[S] != '0) || !sub_diff[W];
                        k_q     <= '0;
                    end else begin
                        k_q <= k_q + IW'(1);
                    end
                end
                OUT: begin
                    if (out_ready_i) k_q <= (k_q == K_LAST) ? '0 : k_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready_o  = (state_q == LOAD);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = (state_q == OUT);
    assign out_last_o  = out_valid_o && (k_q == K_LAST);
    assign res_o       = out_valid_o ? res_word : '0;

endmodule

// File: tb/tb_fios_mm_serial.sv
// Directed and randomized checks of fios_mm_serial across four parameter sets.
module tb_fios_mm_serial;
    typedef logic [135:0] wide_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [1:0]  sel = 2'd0;
    logic        g_start = 1'b0, g_valid = 1'b0, g_oready = 1'b1;
    logic [16:0] g_a = '0, g_b = '0, g_p = '0, g_pp = '0;
    logic        g_iready, g_busy, g_ovalid, g_last;
    logic [16:0] g_res;

    logic [3:0]  ir, bz, ov, ls;
    logic [3:0]  r0, r1;
    logic [16:0] r2;
    logic [15:0] r3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fios_mm_serial #(.W(4), .S(2), .FINAL_SUB(1)) u0 (
        .clock_i(clk), .reset_i(rst), .start_i(g_start && sel == 2'd0), .p_prime_0_i(g_pp[3:0]),
        .in_valid_i(g_valid && sel == 2'd0), .in_ready_o(ir[0]), .a_i(g_a[3:0]), .b_i(g_b[3:0]),
        .p_i(g_p[3:0]), .busy_o(bz[0]), .out_valid_o(ov[0]), .out_ready_i(g_oready && sel == 2'd0),
        .res_o(r0), .out_last_o(ls[0]));
    fios_mm_serial #(.W(4), .S(2), .FINAL_SUB(0)) u1 (
        .clock_i(clk), .reset_i(rst), .start_i(g_start && sel == 2'd1), .p_prime_0_i(g_pp[3:0]),
        .in_valid_i(g_valid && sel == 2'd1), .in_ready_o(ir[1]), .a_i(g_a[3:0]), .b_i(g_b[3:0]),
        .p_i(g_p[3:0]), .busy_o(bz[1]), .out_valid_o(ov[1]), .out_ready_i(g_oready && sel == 2'd1),
        .res_o(r1), .out_last_o(ls[1]));
    fios_mm_serial #(.W(17), .S(8), .FINAL_SUB(1)) u2 (
        .clock_i(clk), .reset_i(rst), .start_i(g_start && sel == 2'd2), .p_prime_0_i(g_pp),
        .in_valid_i(g_valid && sel == 2'd2), .in_ready_o(ir[2]), .a_i(g_a), .b_i(g_b),
        .p_i(g_p), .busy_o(bz[2]), .out_valid_o(ov[2]), .out_ready_i(g_oready && sel == 2'd2),
        .res_o(r2), .out_last_o(ls[2]));
    fios_mm_serial #(.W(16), .S(3), .FINAL_SUB(1)) u3 (
        .clock_i(clk), .reset_i(rst), .start_i(g_start && sel == 2'd3), .p_prime_0_i(g_pp[15:0]),
        .in_valid_i(g_valid && sel == 2'd3), .in_ready_o(ir[3]), .a_i(g_a[15:0]), .b_i(g_b[15:0]),
        .p_i(g_p[15:0]), .busy_o(bz[3]), .out_valid_o(ov[3]), .out_ready_i(g_oready && sel == 2'd3),
        .res_o(r3), .out_last_o(ls[3]));

    always_comb begin
        g_iready = ir[sel];
        g_busy   = bz[sel];
        g_ovalid = ov[sel];
        g_last   = ls[sel];
        case (sel)
            2'd0:    g_res = {13'd0, r0};
            2'd1:    g_res = {13'd0, r1};
            2'd2:    g_res = r2;
            default: g_res = {1'b0, r3};
        endcase
    end

    // The top word of t must stay 0 or 1; anything larger means the carry chain overflowed.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (u0.t_q[2] > 4'd1 || u1.t_q[2] > 4'd1 || u2.t_q[8] > 17'd1 || u3.t_q[3] > 16'd1) begin
                errors++;
                $display("FAIL carry_overflow: t[S] = %0h %0h %0h %0h, required <= 1",
                         u0.t_q[2], u1.t_q[2], u2.t_q[8], u3.t_q[3]);
            end
        end
    end

    task automatic do_start(input logic [1:0] s, input logic [16:0] pp, output int c0);
        sel = s; g_pp = pp; g_valid = 1'b0; g_oready = 1'b1; g_start = 1'b1;
        c0 = cyc;
    endtask

    task automatic send_op(input int wn, input int sn, input wide_t a, input wide_t b,
                           input wide_t p, input bit gap);
        logic [16:0] wm;
        int n;
        wm = (17'd1 << wn) - 17'd1;
        for (int k = 0; k < sn; k++) begin
            @(negedge clk);
            g_start = 1'b0;
            if (gap && k == 1) begin
                g_valid = 1'b0; g_a = '1; g_b = '1; g_p = '1;
                @(negedge clk);
            end
            g_a = 17'(a >> (k * wn)) & wm;
            g_b = 17'(b >> (k * wn)) & wm;
            g_p = 17'(p >> (k * wn)) & wm;
            g_valid = 1'b1;
            n = 0;
            while (!g_iready && n < 50) begin @(negedge clk); n++; end
            if (!g_iready) begin
                checks++; errors++;
                $display("FAIL load_ready: in_ready_o stayed 0 at word %0d, required 1", k);
                g_valid = 1'b0;
                return;
            end
        end
        @(negedge clk);
        g_valid = 1'b0;
    endtask

    task automatic recv_op(input int wn, input int sn, input int c0, input bit stall,
                           input bit pulse, output wide_t res, output int first,
                           output logic [7:0] lastm, output bit stable_ok, output logic busy_after);
        int n;
        logic [16:0] w;
        res = '0; lastm = '0; stable_ok = 1'b1; first = -1; busy_after = 1'b1;
        g_oready = 1'b1;
        n = 0;
        while (!g_ovalid && n < 3000) begin
            @(negedge clk);
            n++;
            g_start = pulse && (n % 3 == 1);
        end
        g_start = 1'b0;
        if (!g_ovalid) begin
            checks++; errors++;
            $display("FAIL out_timeout: out_valid_o stayed 0, required 1");
            return;
        end
        first = cyc - c0;
        for (int k = 0; k < sn; k++) begin
            if (!g_ovalid) begin
                checks++; errors++;
                $display("FAIL out_word_valid: out_valid_o 0 at word %0d, required 1", k);
                return;
            end
            if (stall && k == 0) begin
                g_oready = 1'b0;
                w = g_res;
                repeat (3) begin
                    @(negedge clk);
                    if (g_res !== w || g_ovalid !== 1'b1) stable_ok = 1'b0;
                end
                g_oready = 1'b1;
            end
            res = res | (wide_t'(g_res) << (k * wn));
            lastm[k] = g_last;
            @(negedge clk);
        end
        busy_after = g_busy;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            checks++;
            if ({g_busy, g_ovalid, g_iready, g_last} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: busy/ovalid/iready/last = %b, required 0000", s,
                         {g_busy, g_ovalid, g_iready, g_last});
            end
            checks++;
            if (g_res !== 17'd0) begin
                errors++;
                $display("FAIL reset_res[%0d]: res_o = %0h, required 0", s, g_res);
            end
        end
        checks++;
        if ({u0.t_q[0], u0.t_q[1], u0.t_q[2]} !== 12'h000) begin
            errors++;
            $display("FAIL reset_t: t = %0h, required 0", {u0.t_q[2], u0.t_q[1], u0.t_q[0]});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int c0, first; wide_t res; logic [7:0] lm; bit st; logic ba;
        do_start(2'd0, 17'h9, c0);
        send_op(4, 2, 136'h49, 136'h05, 136'hB7, 1'b0);
        recv_op(4, 2, c0, 1'b0, 1'b0, res, first, lm, st, ba);
        checks++;
        if (res !== 136'h05) begin errors++; $display("FAIL basic_res: got %0h required 5", res); end
        checks++;
        if (first !== 11) begin errors++; $display("FAIL basic_latency: got %0d required 11", first); end
        checks++;
        if (lm[1:0] !== 2'b10) begin errors++; $display("FAIL basic_last: got %b required 10", lm[1:0]); end
        checks++;
        if (ba !== 1'b0) begin errors++; $display("FAIL basic_idle: busy_o %b required 0", ba); end
    endtask

    task automatic test_p_minus_1;
        int c0, first; wide_t res; logic [7:0] lm; bit st; logic ba;
        @(negedge clk);
        do_start(2'd0, 17'h9, c0);
        send_op(4, 2, 136'h49, 136'hB6, 136'hB7, 1'b0);
        recv_op(4, 2, c0, 1'b0, 1'b0, res, first, lm, st, ba);
        checks++;
        if (res !== 136'hB6) begin errors++; $display("FAIL pm1_res: got %0h required B6", res); end
        @(negedge clk);
        do_start(2'd1, 17'h9, c0);
        send_op(4, 2, 136'h49, 136'hB6, 136'hB7, 1'b0);
        recv_op(4, 2, c0, 1'b0, 1'b0, res, first, lm, st, ba);
        checks++;
        if (first !== 9) begin errors++; $display("FAIL nosub_latency: got %0d required 9", first); end
        checks++;
        if ((res % 136'hB7) !== 136'hB6 || res >= 136'h16E) begin
            errors++;
            $display("FAIL nosub_res: got %0h required congruent to B6 and < 16E", res);
        end
    endtask

    task automatic test_back_to_back;
        int c0, first; wide_t res; logic [7:0] lm; bit st; logic ba;
        @(negedge clk);
        do_start(2'd0, 17'h9, c0);
        send_op(4, 2, 136'h00, 136'h42, 136'hB7, 1'b0);
        recv_op(4, 2, c0, 1'b0, 1'b0, res, first, lm, st, ba);
        checks++;
        if (res !== 136'h0) begin errors++; $display("FAIL b2b_zero: got %0h required 0", res); end
        checks++;
        if (ba !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy_o %b required 0", ba); end
        do_start(2'd0, 17'h9, c0);
        send_op(4, 2, 136'h49, 136'h49, 136'hB7, 1'b0);
        recv_op(4, 2, c0, 1'b0, 1'b0, res, first, lm, st, ba);
        checks++;
        if (res !== 136'h49) begin errors++; $display("FAIL b2b_res: got %0h required 49", res); end
        checks++;
        if (first !== 11) begin errors++; $display("FAIL b2b_latency: got %0d required 11", first); end
    endtask

    task automatic test_stall;
        int c0, first; wide_t res; logic [7:0] lm; bit st; logic ba;
        @(negedge clk);
        do_start(2'd0, 17'h9, c0);
        send_op(4, 2, 136'h49, 136'h05, 136'hB7, 1'b1);
        recv_op(4, 2, c0, 1'b1, 1'b1, res, first, lm, st, ba);
        checks++;
        if (res !== 136'h05) begin errors++; $display("FAIL stall_res: got %0h required 5", res); end
        checks++;
        if (first !== 12) begin errors++; $display("FAIL stall_latency: got %0d required 12", first); end
        checks++;
        if (st !== 1'b1) begin errors++; $display("FAIL stall_hold: res_o stable %b required 1", st); end
        checks++;
        if (ba !== 1'b0) begin errors++; $display("FAIL stall_idle: busy_o %b required 0", ba); end
        @(negedge clk);
        checks++;
        if (g_busy !== 1'b0) begin errors++; $display("FAIL stall_no_restart: busy_o %b required 0", g_busy); end
    endtask

    task automatic test_reset_calc;
        int c0, first; wide_t res; logic [7:0] lm; bit st; logic ba;
        @(negedge clk);
        do_start(2'd0, 17'h9, c0);
        send_op(4, 2, 136'h49, 136'hB6, 136'hB7, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({g_busy, g_ovalid} !== 2'b00) begin
            errors++;
            $display("FAIL abort_ctrl: busy/ovalid = %b required 00", {g_busy, g_ovalid});
        end
        checks++;
        if ({u0.t_q[0], u0.t_q[1], u0.t_q[2]} !== 12'h000) begin
            errors++;
            $display("FAIL abort_t: t = %0h required 0", {u0.t_q[2], u0.t_q[1], u0.t_q[0]});
        end
        rst = 1'b0;
        @(negedge clk);
        do_start(2'd0, 17'h9, c0);
        send_op(4, 2, 136'h49, 136'h49, 136'hB7, 1'b0);
        recv_op(4, 2, c0, 1'b0, 1'b0, res, first, lm, st, ba);
        checks++;
        if (res !== 136'h49) begin errors++; $display("FAIL abort_recover: got %0h required 49", res); end
    endtask

    task automatic test_random(input logic [1:0] s, input int wn, input int sn, input int count);
        wide_t mask, p, a, b, res;
        logic [159:0] rnd;
        logic [271:0] lhs, rhs;
        logic [16:0] inv, p0, wm, pp;
        logic [7:0] lm;
        int c0, first, ws;
        bit st; logic ba;
        ws = wn * sn;
        mask = (wide_t'(1) << ws) - wide_t'(1);
        wm = (17'd1 << wn) - 17'd1;
        for (int v = 0; v < count; v++) begin
            for (int q = 0; q < 5; q++) rnd[q*32 +: 32] = $urandom();
            p = (wide_t'(rnd) & mask) | wide_t'(1);
            p[ws-1] = 1'b1;
            for (int q = 0; q < 5; q++) rnd[q*32 +: 32] = $urandom();
            a = wide_t'(rnd) % p;
            for (int q = 0; q < 5; q++) rnd[q*32 +: 32] = $urandom();
            b = wide_t'(rnd) % p;
            p0 = 17'(p);
            inv = p0;
            repeat (5) inv = inv * (17'd2 - p0 * inv);
            pp = (17'd0 - inv) & wm;
            @(negedge clk);
            do_start(s, pp, c0);
            send_op(wn, sn, a, b, p, 1'b0);
            recv_op(wn, sn, c0, 1'b0, 1'b0, res, first, lm, st, ba);
            lhs = ({136'd0, res} << ws) % {136'd0, p};
            rhs = ({136'd0, a} * {136'd0, b}) % {136'd0, p};
            checks++;
            if (res >= p || lhs !== rhs) begin
                errors++;
                $display("FAIL random_w%0d_s%0d: a=%0h b=%0h p=%0h got %0h, required res<p and res*R==a*b mod p",
                         wn, sn, a, b, p, res);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_p_minus_1;
        test_back_to_back;
        test_stall;
        test_reset_calc;
        test_random(2'd2, 17, 8, 250);
        test_random(2'd3, 16, 3, 1000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
